// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: the retire record carried through the FIFO.
package commit_trace_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0]     seq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic            mem_wrt;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } commit_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through sync FIFO with extra-MSB pointers and a synchronous flush.
module trace_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  T                       wr_data,
  output logic                   wr_accept,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output T                       rd_data,
  output logic                   rd_fire,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_addr;
  T              mem [DEPTH];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign rd_valid = ~empty;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // A flush discards the head, so a pop presented with it never happens.
  assign rd_fire   = rd_valid & rd_ready & ~flush;
  assign wr_accept = wr_en & (flush | ~full | rd_fire);
  assign wr_addr   = flush ? '0 : wr_ptr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= {{AW{1'b0}}, wr_accept};
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset; contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures core retire events, normalises and sequence-numbers them, and buffers them for a
// valid/ready trace consumer. Overflowing events are dropped and counted.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = commit_trace_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   update_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [4:0]             reg_addr_i,
  input  logic [XLEN-1:0]        reg_data_i,
  input  logic [XLEN-1:0]        mem_addr_i,
  input  logic [XLEN-1:0]        mem_data_i,
  input  logic                   mem_wrt_i,
  input  logic                   flush_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output commit_rec_t            trace_rec_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       drop_cnt_o
);

  logic        update_q;
  logic        evt;
  logic        accept;
  logic        pop_fire;
  logic [31:0] seq;
  commit_rec_t cap_rec;

  // update_q starts high so a strobe already high at reset release is not an event.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) update_q <= 1'b1;
    else         update_q <= update_i;
  end

  assign evt = update_i & ~update_q;

  always_comb begin
    cap_rec          = '0;
    cap_rec.seq      = seq;
    cap_rec.pc       = pc_i;
    cap_rec.instr    = instr_i;
    cap_rec.reg_addr = reg_addr_i;
    cap_rec.reg_data = (reg_addr_i != 5'd0) ? reg_data_i : '0;
    cap_rec.mem_wrt  = mem_wrt_i;
    cap_rec.mem_addr = mem_wrt_i ? mem_addr_i : '0;
    cap_rec.mem_data = mem_wrt_i ? mem_data_i : '0;
  end

  // Sequence advances on dropped events too, so gaps are visible downstream.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)  seq <= '0;
    else if (evt) seq <= seq + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      drop_cnt_o <= '0;
    else if (evt && !accept && (drop_cnt_o != {CNT_W{1'b1}}))
      drop_cnt_o <= drop_cnt_o + 1'b1;
  end

  trace_fifo #(
    .T     (commit_rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .flush     (flush_i),
    .wr_en     (evt),
    .wr_data   (cap_rec),
    .wr_accept (accept),
    .rd_ready  (trace_ready_i),
    .rd_valid  (trace_valid_o),
    .rd_data   (trace_rec_o),
    .rd_fire   (pop_fire),
    .level     (level_o),
    .full      (full_o),
    .empty     (empty_o)
  );

  // pop_fire is consumed inside the FIFO; kept here for probing.
  logic unused_pop;
  assign unused_pop = pop_fire;

endmodule
